// File: rtl/fwd_pkg.sv
// Shared widths, Tuse encodings and the history entry layout for the forwarding unit.
package fwd_pkg;

    localparam int TNEW_W = 2;

    localparam logic [TNEW_W-1:0] TUSE_D = 2'd0;
    localparam logic [TNEW_W-1:0] TUSE_E = 2'd1;
    localparam logic [TNEW_W-1:0] TUSE_M = 2'd2;

    // Entry layout for the default 32-bit, 32-register configuration.
    localparam int HIST_XLEN = 32;
    localparam int HIST_AW   = 5;

    typedef struct packed {
        logic                 valid;
        logic [HIST_AW-1:0]   a3;
        logic [HIST_XLEN-1:0] data;
    } hist_entry_t;

    // Busy counter must hold the longest latency, never narrower than 4 bits.
    function automatic int md_cnt_width(input int mult_lat, input int div_lat);
        int m;
        int w;
        m = (mult_lat > div_lat) ? mult_lat : div_lat;
        w = $clog2(m + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_hist_buf.sv
// Shift register of retired W-stage writes; shifts every clock since W always retires.
module fwd_hist_buf #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int HIST_DEPTH = 1,
    localparam int HD        = (HIST_DEPTH > 0) ? HIST_DEPTH : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            w_we,
    input  logic [AW-1:0]   w_a3,
    input  logic [XLEN-1:0] w_out,
    output logic [HD-1:0]   hist_vld,
    output logic [AW-1:0]   hist_a3  [HD],
    output logic [XLEN-1:0] hist_dat [HD]
);

    if (HIST_DEPTH > 0) begin : g_hist
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < HD; i++) begin
                    hist_vld[i] <= 1'b0;
                    hist_a3[i]  <= '0;
                    hist_dat[i] <= '0;
                end
            end else begin
                hist_vld[0] <= w_we && (w_a3 != '0);
                hist_a3[0]  <= w_a3;
                hist_dat[0] <= w_out;
                for (int i = 1; i < HD; i++) begin
                    hist_vld[i] <= hist_vld[i-1];
                    hist_a3[i]  <= hist_a3[i-1];
                    hist_dat[i] <= hist_dat[i-1];
                end
            end
        end
    end else begin : g_no_hist
        logic unused_hist_in;
        assign unused_hist_in = ^{clk, reset, w_we, w_a3, w_out};
        assign hist_vld    = '0;
        assign hist_a3[0]  = '0;
        assign hist_dat[0] = '0;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass, Tnew/Tuse data-stall and mult/div busy tracking for the D/E/M/W pipeline.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int HIST_DEPTH = 1,
    parameter int MULT_LAT   = 5,
    parameter int DIV_LAT    = 10,
    localparam int AW        = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     d_rs_addr,
    input  logic [AW-1:0]     d_rt_addr,
    input  logic [TNEW_W-1:0] d_rs_tuse,
    input  logic [TNEW_W-1:0] d_rt_tuse,
    input  logic [XLEN-1:0]   d_rs_rd,
    input  logic [XLEN-1:0]   d_rt_rd,
    input  logic              d_md_use,
    input  logic [AW-1:0]     e_rs_addr,
    input  logic [AW-1:0]     e_rt_addr,
    input  logic [XLEN-1:0]   e_rs_rd,
    input  logic [XLEN-1:0]   e_rt_rd,
    input  logic [AW-1:0]     m_rt_addr,
    input  logic [XLEN-1:0]   m_rt_rd,
    input  logic [AW-1:0]     e_a3,
    input  logic [AW-1:0]     m_a3,
    input  logic [AW-1:0]     w_a3,
    input  logic              e_we,
    input  logic              m_we,
    input  logic              w_we,
    input  logic [TNEW_W-1:0] e_tnew,
    input  logic [TNEW_W-1:0] m_tnew,
    input  logic [XLEN-1:0]   e_out,
    input  logic [XLEN-1:0]   m_out,
    input  logic [XLEN-1:0]   w_out,
    input  logic              md_start,
    input  logic              md_is_div,
    output logic [XLEN-1:0]   fw_d_rs,
    output logic [XLEN-1:0]   fw_d_rt,
    output logic [XLEN-1:0]   fw_e_rs,
    output logic [XLEN-1:0]   fw_e_rt,
    output logic [XLEN-1:0]   fw_m_rt,
    output logic              stall,
    output logic              md_busy
);

    localparam int HD = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;
    localparam int CW = md_cnt_width(MULT_LAT, DIV_LAT);

    logic [HD-1:0]   hist_vld;
    logic [AW-1:0]   hist_a3  [HD];
    logic [XLEN-1:0] hist_dat [HD];
    logic [CW-1:0]   md_cnt;

    fwd_hist_buf #(
        .XLEN       (XLEN),
        .AW         (AW),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .w_we     (w_we),
        .w_a3     (w_a3),
        .w_out    (w_out),
        .hist_vld (hist_vld),
        .hist_a3  (hist_a3),
        .hist_dat (hist_dat)
    );

    // Walk oldest to youngest so the youngest match overwrites; an unready youngest
    // writer masks every older one by restoring the fallback.
    function automatic logic [XLEN-1:0] fwd_val(input logic [AW-1:0] a, input logic [XLEN-1:0] rd,
                                               input logic use_e, input logic use_m);
        logic [XLEN-1:0] v;
        v = rd;
        for (int i = HD - 1; i >= 0; i--) begin
            if (hist_vld[i] && hist_a3[i] == a) v = hist_dat[i];
        end
        if (w_we && w_a3 == a) v = w_out;
        if (use_m && m_we && m_a3 == a) v = (m_tnew == '0) ? m_out : rd;
        if (use_e && e_we && e_a3 == a) v = (e_tnew == '0) ? e_out : rd;
        if (a == '0) v = '0;
        return v;
    endfunction

    function automatic logic src_stall(input logic [AW-1:0] a, input logic [TNEW_W-1:0] tuse);
        logic e_hit;
        logic m_hit;
        e_hit = e_we && (e_a3 == a) && (a != '0);
        m_hit = m_we && (m_a3 == a) && (a != '0);
        return (e_hit && e_tnew > tuse) || (!e_hit && m_hit && m_tnew > tuse);
    endfunction

    assign fw_d_rs = fwd_val(d_rs_addr, d_rs_rd, 1'b1, 1'b1);
    assign fw_d_rt = fwd_val(d_rt_addr, d_rt_rd, 1'b1, 1'b1);
    assign fw_e_rs = fwd_val(e_rs_addr, e_rs_rd, 1'b0, 1'b1);
    assign fw_e_rt = fwd_val(e_rt_addr, e_rt_rd, 1'b0, 1'b1);
    assign fw_m_rt = fwd_val(m_rt_addr, m_rt_rd, 1'b0, 1'b0);

    assign md_busy = md_start || (md_cnt != '0);
    assign stall   = src_stall(d_rs_addr, d_rs_tuse) || src_stall(d_rt_addr, d_rt_tuse)
                   || (d_md_use && md_busy);

    // A restart while busy simply reloads with the new operation's latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (md_start) begin
            md_cnt <= md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

endmodule
